// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one ROM/RAM memory bus between two requesters. Port 0 is the core
// controller and port 1 is the program loader / debug port. Arbitration is
// round-robin. The winning command is registered and then drives the memory
// strobes for ACC_CYC cycles. Read data is captured and a one-cycle done pulse
// is returned to the winner.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   reqN, weN, romN             request, write(1)/read(0), target ROM(1)/RAM(0)
//   addrN, wdataN               command address / write data
//   gntN                        command accepted (1-cycle pulse)
//   doneN, errN                 access complete; err flags an attempted ROM write
//   rdata                       read data, valid while done0/done1 is high
//   mem_addr, mem_wdata         address / write data to ROM and RAM
//   mem_rdata                   read data returned by ROM or RAM
//   rom_ena, rom_read           ROM strobes
//   ram_ena, ram_read, ram_write RAM strobes
//
// Every output is driven directly from a register.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ACC_CYC = 1,
  parameter int AW      = 8,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic          rom0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic          rom1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rom_ena,
  output logic          rom_read,
  output logic          ram_ena,
  output logic          ram_read,
  output logic          ram_write
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter holds the remaining strobe cycles after the current one.
  localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_last;
  logic          r_win;
  logic          r_we;
  logic          r_rom;
  logic          r_gnt0, r_gnt1;
  logic          r_done0, r_done1;
  logic          r_err0, r_err1;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_rom_ena, r_rom_read;
  logic          r_ram_ena, r_ram_read, r_ram_write;

  logic          w_pick;
  logic          w_we;
  logic          w_rom;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // A lone requester always wins. On a tie the port not served last wins,
  // which yields strict alternation under continuous contention.
  assign w_pick  = (req0 && req1) ? ~r_last : req1;
  assign w_we    = w_pick ? we1    : we0;
  assign w_rom   = w_pick ? rom1   : rom0;
  assign w_addr  = w_pick ? addr1  : addr0;
  assign w_wdata = w_pick ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_we        <= 1'b0;
      r_rom       <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rom_ena   <= 1'b0;
      r_rom_read  <= 1'b0;
      r_ram_ena   <= 1'b0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
    end else begin
      // Handshake pulses last exactly one cycle.
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_win      <= w_pick;
            r_last     <= w_pick;
            r_we       <= w_we;
            r_rom      <= w_rom;
            r_mem_addr <= w_addr;
            if (w_we && !w_rom) begin
              r_mem_wdata <= w_wdata;
            end
            r_gnt0      <= ~w_pick;
            r_gnt1      <= w_pick;
            r_cnt       <= CNT_INIT;
            // A ROM write is illegal; it runs its cycles with no strobes.
            r_rom_ena   <= w_rom & ~w_we;
            r_rom_read  <= w_rom & ~w_we;
            r_ram_ena   <= ~w_rom;
            r_ram_read  <= ~w_rom & ~w_we;
            r_ram_write <= ~w_rom & w_we;
            r_state     <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              r_rdata <= mem_rdata;
            end
            r_rom_ena   <= 1'b0;
            r_rom_read  <= 1'b0;
            r_ram_ena   <= 1'b0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            r_done0     <= ~r_win;
            r_done1     <= r_win;
            r_err0      <= ~r_win & r_we & r_rom;
            r_err1      <= r_win & r_we & r_rom;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rom_ena   = r_rom_ena;
  assign rom_read  = r_rom_read;
  assign ram_ena   = r_ram_ena;
  assign ram_read  = r_ram_read;
  assign ram_write = r_ram_write;

endmodule
